ram_counter_bank: RTL and testbench
===================================

Name: ram_counter_bank

Overview:
- Parametrised successor to the RAM-backed loadable counter. One WIDTH-bit up/down counter with on-chip tick generation, so no derived clocks are needed.
- Uses a DEPTH-entry snapshot RAM and a valid/ready command port: STORE (CNT -> slot), LOAD (slot -> CNT), CLEAR (zero all slots).
- Sits between the front-panel/control logic and the display path, in the single system clock domain.

Parameters:
- WIDTH, 8, counter and RAM data width (2..32).
- DEPTH, 16, snapshot slots (power of 2, >=2); AW = clog2(DEPTH).
- TICK_DIV, 50, clk cycles per count tick (>=1; 1 means tick every cycle).
- SATURATE, 0, 0 = wrap at limits; 1 = hold at limits.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- EN  in  1  count enable, sampled on tick cycles.
- UP  in  1  1 = count up, 0 = count down.
- cmd_valid  in  1  command request.
- cmd_op  in  2  0 STORE, 1 LOAD, 2 CLEAR, 3 NOP.
- cmd_addr  in  AW  slot index; ignored for CLEAR/NOP.
- cmd_ready  out  1  block can accept a command.
- done  out  1  one-cycle pulse on command completion.
- tick  out  1  one-cycle divider pulse.
- limit  out  1  one-cycle pulse when a count step hits or wraps a limit.
- CNT  out  WIDTH  counter value.

Behaviour:
- Reset (synchronous, active-high): CNT=0, divider=0, tick=0, limit=0, done=0, state=IDLE, cmd_ready=0 during the reset cycle. RAM contents are not cleared by reset.
- Divider: counts 0..TICK_DIV-1 and always runs. tick=1 in the cycle the divider equals TICK_DIV-1, then the divider returns to 0.
- Count step on (tick & EN & no LOAD-capture this cycle):
  - UP=1: CNT+1; at 2^WIDTH-1 it wraps to 0 (SATURATE=0) or holds (SATURATE=1).
  - UP=0: CNT-1, mirrored at 0.
  - limit pulses on the edge where CNT wraps, or where a step would exceed a limit (saturate).
- cmd_ready = (state==IDLE). Accept = cmd_valid & cmd_ready at edge E.
- STORE: RAM[cmd_addr] <= CNT value before edge E. Counting at E is unaffected. State stays IDLE; done=1 for the cycle after E. Back-to-back STOREs run at 1 per cycle.
- LOAD: sync read issued at E; state=READ. At E+1, CNT <= RAM q (1-cycle RAM latency) and any tick at E+1 is dropped (load wins). State=IDLE; done=1 for the cycle after E+1. cmd_ready=0 during READ.
- CLEAR: state=CLEAR; writes 0 to slots 0..DEPTH-1, one per cycle, starting at E+1. Last write at E+DEPTH. done pulse follows the last write, then IDLE. Counting continues throughout.
- NOP: accepted, done pulse next cycle, no other effect.
- Read-during-write to the same slot returns old data; this cannot occur internally because LOAD blocks new commands.
- Reset mid-LOAD/CLEAR aborts immediately: CNT=0, no done pulse. Slots already cleared stay cleared.
- All arithmetic is modulo 2^WIDTH; there is no sign.

Decomposition:
- Package ram_counter_pkg: cmd_op encodings (OP_STORE, OP_LOAD, OP_CLEAR, OP_NOP) and state enum (IDLE, READ, CLEAR).
- Sub-module ram_counter_store: DEPTH x WIDTH simple dual-port RAM with 1-cycle sync read (inferred array, no vendor IP).
- Divider, counter and FSM live in ram_counter_bank.

Test Plan (WIDTH=8, DEPTH=16, TICK_DIV=4 unless noted):
- Reset then EN=1, UP=1 for 40 cycles -> tick every 4th cycle, CNT=10, limit=0.
- Force CNT=255 via LOAD, UP=1, one tick -> CNT=0 and limit pulse. With SATURATE=1 -> CNT=255, limit pulse.
- CNT=37, STORE slot 5; count to 42; LOAD slot 5 -> CNT=37 two edges after accept, done 1 cycle, cmd_ready low 1 cycle.
- LOAD issued so capture coincides with tick, EN=1 -> CNT equals loaded value exactly (tick dropped).
- Store 9 to slots 0..15, CLEAR -> cmd_ready low 16 cycles, done once, then LOAD each slot -> 0.
- Assert Reset during CLEAR at step 7 -> slots 0..6 read 0, slots 7..15 read 9, CNT=0, no done.

Source files
------------

// File: rtl/ram_counter_pkg.sv
// Shared encodings for the RAM-backed counter bank.
//   cmd_op_e : command opcodes carried on the command port
//   state_e  : command sequencer states
package ram_counter_pkg;

  typedef enum logic [1:0] {
    OP_STORE = 2'd0,
    OP_LOAD  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_NOP   = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/ram_counter_bank_if.sv
// Command port of the counter bank: valid/ready request plus done pulse.
//   cmd_valid/cmd_op/cmd_addr : request from the control logic (master)
//   cmd_ready                 : bank can take a command this cycle
//   done                      : one-cycle completion pulse
interface ram_counter_bank_if #(
  parameter int AW = 4
);
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic          cmd_ready;
  logic          done;

  modport master (output cmd_valid, cmd_op, cmd_addr, input cmd_ready, done);
  modport slave  (input cmd_valid, cmd_op, cmd_addr, output cmd_ready, done);
endinterface

// File: rtl/ram_counter_store.sv
// Snapshot RAM: DEPTH x WIDTH simple dual-port array, one write port and
// one read port with a single cycle of read latency.
//   clk_i             : clock
//   we_i/waddr_i/wdata_i : write port
//   raddr_i/rdata_o   : read port, rdata_o valid the cycle after raddr_i
// A read to the slot being written returns the old contents.
module ram_counter_store #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/ram_counter_bank.sv
// Up/down counter with internal tick divider and a snapshot RAM driven
// through a valid/ready command port (STORE, LOAD, CLEAR, NOP).
//   clk_i   : system clock          rst_i : synchronous active-high reset
//   en_i    : count enable          up_i  : 1 = up, 0 = down
//   cmd     : command interface (slave side)
//   tick_o  : divider pulse         limit_o : pulse on wrap / saturate hit
//   cnt_o   : counter value
module ram_counter_bank
  import ram_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 50,
  parameter int SATURATE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             up_i,
  ram_counter_bank_if.slave cmd,
  output logic             tick_o,
  output logic             limit_o,
  output logic [WIDTH-1:0] cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [WIDTH-1:0] CMAX = '1;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    clr_q, clr_d;
  logic             done_q, done_d;
  logic             limit_q, limit_d;

  logic             at_end, ready, accept, step;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] ram_wdata, ram_rdata;

  assign at_end = (div_q == DW'(TICK_DIV - 1));
  assign div_d  = at_end ? '0 : div_q + DW'(1);
  assign ready  = (state_q == IDLE) && !rst_i;
  assign accept = cmd.cmd_valid && ready;
  // The LOAD capture edge owns the counter; a coincident tick is dropped.
  assign step   = at_end && en_i && (state_q != READ);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      clr_q   <= '0;
      done_q  <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      limit_q <= limit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    done_d    = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = cmd.cmd_addr;
    ram_wdata = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (cmd_op_e'(cmd.cmd_op))
            OP_STORE: begin ram_we = 1'b1; done_d = 1'b1; end
            OP_LOAD:  state_d = READ;
            OP_CLEAR: begin state_d = CLEAR; clr_d = '0; end
            default:  done_d = 1'b1;
          endcase
        end
      end
      READ: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_q;
        ram_wdata = '0;
        clr_d     = clr_q + AW'(1);
        if (clr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_d   = cnt_q;
    limit_d = 1'b0;
    if (state_q == READ) begin
      cnt_d = ram_rdata;
    end else if (step) begin
      if (up_i) begin
        if (cnt_q == CMAX) begin
          limit_d = 1'b1;
          cnt_d   = (SATURATE != 0) ? CMAX : '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          limit_d = 1'b1;
          cnt_d   = (SATURATE != 0) ? '0 : CMAX;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  // Writes are blocked during reset so an aborted CLEAR stops immediately.
  ram_counter_store #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_store (
    .clk_i   (clk_i),
    .we_i    (ram_we && !rst_i),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (cmd.cmd_addr),
    .rdata_o (ram_rdata)
  );

  assign cmd.cmd_ready = ready;
  assign cmd.done      = done_q;
  assign tick_o        = at_end && !rst_i;
  assign limit_o       = limit_q;
  assign cnt_o         = cnt_q;
endmodule

// File: tb/tb_ram_counter_bank.sv
module tb_ram_counter_bank;
  localparam int TDIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic up  = 1'b1;
  logic tick0, tick1, lim0, lim1;
  logic [7:0] cnt0, cnt1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_counter_bank_if #(.AW(4)) bus0 ();
  ram_counter_bank_if #(.AW(4)) bus1 ();
  assign bus1.cmd_valid = bus0.cmd_valid;
  assign bus1.cmd_op    = bus0.cmd_op;
  assign bus1.cmd_addr  = bus0.cmd_addr;

  ram_counter_bank #(.WIDTH(8), .DEPTH(16), .TICK_DIV(TDIV), .SATURATE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .cmd(bus0.slave),
    .tick_o(tick0), .limit_o(lim0), .cnt_o(cnt0));
  ram_counter_bank #(.WIDTH(8), .DEPTH(16), .TICK_DIV(TDIV), .SATURATE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .cmd(bus1.slave),
    .tick_o(tick1), .limit_o(lim1), .cnt_o(cnt1));

  // Reference model: index 0 wraps, index 1 saturates. m_mode 0 idle,
  // 1 load pending, 2 clearing.
  logic [7:0] m_cnt [2];
  logic [7:0] m_ram [2][16];
  logic       m_lim [2];
  logic       m_done;
  int m_div, m_mode, m_addr, m_ptr;

  always @(posedge clk) begin : model
    logic tk, cap;
    logic [7:0] old [2];
    if (rst) begin
      m_div = 0; m_mode = 0; m_done = 1'b0;
      for (int s = 0; s < 2; s++) begin m_cnt[s] = 8'd0; m_lim[s] = 1'b0; end
    end else begin
      tk = (m_div == TDIV - 1);
      m_div = (m_div + 1) % TDIV;
      cap = (m_mode == 1);
      m_done = 1'b0;
      for (int s = 0; s < 2; s++) begin
        old[s] = m_cnt[s];
        m_lim[s] = 1'b0;
        if (tk && en && !cap) begin
          if (up) begin
            if (m_cnt[s] == 8'd255) begin m_lim[s] = 1'b1; m_cnt[s] = (s == 1) ? 8'd255 : 8'd0; end
            else m_cnt[s] = m_cnt[s] + 8'd1;
          end else begin
            if (m_cnt[s] == 8'd0) begin m_lim[s] = 1'b1; m_cnt[s] = (s == 1) ? 8'd0 : 8'd255; end
            else m_cnt[s] = m_cnt[s] - 8'd1;
          end
        end
      end
      if (m_mode == 1) begin
        for (int s = 0; s < 2; s++) m_cnt[s] = m_ram[s][m_addr];
        m_mode = 0; m_done = 1'b1;
      end else if (m_mode == 2) begin
        for (int s = 0; s < 2; s++) m_ram[s][m_ptr] = 8'd0;
        if (m_ptr == 15) begin m_mode = 0; m_done = 1'b1; end
        m_ptr = m_ptr + 1;
      end else if (bus0.cmd_valid) begin
        case (bus0.cmd_op)
          2'd0: begin for (int s = 0; s < 2; s++) m_ram[s][bus0.cmd_addr] = old[s]; m_done = 1'b1; end
          2'd1: begin m_mode = 1; m_addr = int'(bus0.cmd_addr); end
          2'd2: begin m_mode = 2; m_ptr = 0; end
          default: m_done = 1'b1;
        endcase
      end
    end
  end

  wire rdy_e = (m_mode == 0) && !rst;
  wire tk_e  = (m_div == TDIV - 1) && !rst;
  wire [23:0] obs   = {cnt0, cnt1, bus0.done, bus1.done, lim0, lim1,
                       bus0.cmd_ready, bus1.cmd_ready, tick0, tick1};
  wire [23:0] exp_v = {m_cnt[0], m_cnt[1], m_done, m_done, m_lim[0], m_lim[1],
                       rdy_e, rdy_e, tk_e, tk_e};

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; bus0.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] a);
    bus0.cmd_valid = 1'b1; bus0.cmd_op = op; bus0.cmd_addr = a;
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
  endtask

  task automatic fill_nines();
    do_reset();
    en = 1'b1; up = 1'b1;
    repeat (36) @(negedge clk);
    en = 1'b0;
    bus0.cmd_valid = 1'b1; bus0.cmd_op = 2'd0;
    for (int a = 0; a < 16; a++) begin
      bus0.cmd_addr = 4'(a);
      @(negedge clk);
    end
    bus0.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; up = 1'b1;
    bus0.cmd_valid = 1'b0; bus0.cmd_op = 2'd3; bus0.cmd_addr = 4'd0;
    @(negedge clk);
    @(negedge clk);
    if ({cnt0, cnt1, lim0, lim1, bus0.done, bus0.cmd_ready, tick0} !== 21'd0) begin
      $display("FAIL reset_state got cnt=%0d ready=%b done=%b tick=%b want all 0",
               cnt0, bus0.cmd_ready, bus0.done, tick0);
      bad++;
    end
    total++;
    rst = 1'b0;
  endtask

  task automatic test_count();
    int tks = 0, lims = 0;
    en = 1'b1; up = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (obs !== exp_v) begin $display("FAIL count_cycle got=%h want=%h", obs, exp_v); bad++; end
      total++;
      tks += int'(tick0);
      lims += int'(lim0);
    end
    if (cnt0 !== 8'd10 || tks != 10 || lims != 0) begin
      $display("FAIL count_40 got cnt=%0d ticks=%0d lim=%0d want 10/10/0", cnt0, tks, lims);
      bad++;
    end
    total++;
  endtask

  task automatic test_wrap();
    int l0 = 0, l1 = 0;
    up = 1'b0;
    repeat (44) begin @(negedge clk); l0 += int'(lim0); l1 += int'(lim1); end
    if (cnt0 !== 8'd255 || cnt1 !== 8'd0 || l0 != 1 || l1 != 1) begin
      $display("FAIL wrap_down got cnt0=%0d cnt1=%0d l0=%0d l1=%0d want 255/0/1/1", cnt0, cnt1, l0, l1);
      bad++;
    end
    total++;
    en = 1'b0;
    send(2'd0, 4'd1);
    en = 1'b1; up = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b0;
    send(2'd1, 4'd1);
    @(negedge clk);
    if (cnt0 !== 8'd255) begin $display("FAIL load_255 got=%0d want=255", cnt0); bad++; end
    total++;
    en = 1'b1; l0 = 0;
    repeat (4) begin @(negedge clk); l0 += int'(lim0); end
    en = 1'b0;
    if (cnt0 !== 8'd0 || l0 != 1) begin
      $display("FAIL wrap_up got cnt=%0d lim=%0d want 0/1", cnt0, l0); bad++;
    end
    total++;
  endtask

  task automatic test_saturate();
    int l0 = 0, l1 = 0;
    do_reset();
    en = 1'b1; up = 1'b1;
    repeat (257 * TDIV) begin
      @(negedge clk);
      if (obs !== exp_v) begin $display("FAIL sat_cycle got=%h want=%h", obs, exp_v); bad++; end
      total++;
      l0 += int'(lim0); l1 += int'(lim1);
    end
    en = 1'b0;
    if (cnt0 !== 8'd1 || cnt1 !== 8'd255 || l0 != 1 || l1 != 2) begin
      $display("FAIL saturate got cnt0=%0d cnt1=%0d l0=%0d l1=%0d want 1/255/1/2", cnt0, cnt1, l0, l1);
      bad++;
    end
    total++;
  endtask

  task automatic test_store_load();
    do_reset();
    en = 1'b1; up = 1'b1;
    repeat (37 * TDIV) @(negedge clk);
    en = 1'b0;
    send(2'd0, 4'd5);
    if (cnt0 !== 8'd37 || bus0.done !== 1'b1) begin
      $display("FAIL store_done got cnt=%0d done=%b want 37/1", cnt0, bus0.done); bad++;
    end
    total++;
    en = 1'b1;
    repeat (20) @(negedge clk);
    en = 1'b0;
    if (cnt0 !== 8'd42) begin $display("FAIL count_42 got=%0d want=42", cnt0); bad++; end
    total++;
    bus0.cmd_valid = 1'b1; bus0.cmd_op = 2'd1; bus0.cmd_addr = 4'd5;
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    if (bus0.cmd_ready !== 1'b0 || cnt0 !== 8'd42 || bus0.done !== 1'b0) begin
      $display("FAIL load_busy got ready=%b cnt=%0d done=%b want 0/42/0", bus0.cmd_ready, cnt0, bus0.done);
      bad++;
    end
    total++;
    @(negedge clk);
    if (cnt0 !== 8'd37 || bus0.done !== 1'b1 || bus0.cmd_ready !== 1'b1) begin
      $display("FAIL load_done got cnt=%0d done=%b ready=%b want 37/1/1", cnt0, bus0.done, bus0.cmd_ready);
      bad++;
    end
    total++;
    @(negedge clk);
    if (bus0.done !== 1'b0) begin $display("FAIL done_width got=%b want=0", bus0.done); bad++; end
    total++;
  endtask

  task automatic test_load_tick();
    for (int i = 0; i < 8 && m_div != TDIV - 2; i++) @(negedge clk);
    en = 1'b1; up = 1'b1;
    bus0.cmd_valid = 1'b1; bus0.cmd_op = 2'd1; bus0.cmd_addr = 4'd5;
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    if (tick0 !== 1'b1) begin $display("FAIL tick_align got=%b want=1", tick0); bad++; end
    total++;
    @(negedge clk);
    en = 1'b0;
    if (cnt0 !== 8'd37 || cnt1 !== 8'd37) begin
      $display("FAIL load_wins got cnt0=%0d cnt1=%0d want 37", cnt0, cnt1); bad++;
    end
    total++;
  endtask

  task automatic test_clear();
    int low = 0, dn = 0;
    fill_nines();
    if (cnt0 !== 8'd9 || bus0.done !== 1'b1) begin
      $display("FAIL fill got cnt=%0d done=%b want 9/1", cnt0, bus0.done); bad++;
    end
    total++;
    send(2'd2, 4'd0);
    for (int i = 0; i < 20; i++) begin
      low += int'(!bus0.cmd_ready);
      dn  += int'(bus0.done);
      @(negedge clk);
    end
    if (low != 16 || dn != 1) begin
      $display("FAIL clear_busy got low=%0d done=%0d want 16/1", low, dn); bad++;
    end
    total++;
    for (int a = 0; a < 16; a++) begin
      send(2'd1, 4'(a));
      @(negedge clk);
      if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
        $display("FAIL clear_slot%0d got=%0d want=0", a, cnt0); bad++;
      end
      total++;
    end
  endtask

  task automatic test_clear_reset();
    logic [7:0] want;
    fill_nines();
    send(2'd2, 4'd0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    if (cnt0 !== 8'd0 || bus0.done !== 1'b0) begin
      $display("FAIL abort got cnt=%0d done=%b want 0/0", cnt0, bus0.done); bad++;
    end
    total++;
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      want = (a < 7) ? 8'd0 : 8'd9;
      send(2'd1, 4'(a));
      @(negedge clk);
      if (cnt0 !== want) begin $display("FAIL abort_slot%0d got=%0d want=%0d", a, cnt0, want); bad++; end
      total++;
    end
  endtask

  task automatic test_random();
    repeat (400) begin
      @(negedge clk);
      if (obs !== exp_v) begin $display("FAIL rand_cycle got=%h want=%h", obs, exp_v); bad++; end
      total++;
      en = 1'($urandom_range(0, 1));
      up = 1'($urandom_range(0, 1));
      bus0.cmd_valid = ($urandom_range(0, 2) == 0);
      bus0.cmd_op    = 2'($urandom_range(0, 3));
      bus0.cmd_addr  = 4'($urandom_range(0, 15));
    end
    bus0.cmd_valid = 1'b0;
  endtask

  initial begin
    bus0.cmd_valid = 1'b0; bus0.cmd_op = 2'd3; bus0.cmd_addr = 4'd0;
    test_reset();
    test_count();
    test_wrap();
    test_saturate();
    test_store_load();
    test_load_tick();
    test_clear();
    test_clear_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
